// File: rtl/dmem_responder.sv
// Single-port data memory with a posted-store FIFO in front of it.
// Loads forward from the store buffer; the buffer drains into the array on idle cycles or when full.
module dmem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int SB_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               proc2Dmem_addr,
  input  logic [1:0]                proc2Dmem_command,
  input  logic [31:0]               proc2mem_data,
  output logic [31:0]               mem2proc_data,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      mem_err
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic [31:0]         mem     [MEM_WORDS];
  logic [SB_DEPTH-1:0] sb_valid;
  logic [AW-1:0]       sb_idx  [SB_DEPTH];
  logic [31:0]         sb_data [SB_DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [PW:0]         count;

  logic [AW-1:0]       idx;
  logic                bad;
  logic                is_load;
  logic                is_store;
  logic                is_idle;
  logic [SB_DEPTH-1:0] match;
  logic                hit;
  logic [PW-1:0]       hit_slot;
  logic                push;
  logic                drain;

  assign idx      = proc2Dmem_addr[AW+1:2];
  assign bad      = (proc2Dmem_addr[1:0] != 2'b00) || (proc2Dmem_addr >= 32'(4 * MEM_WORDS));
  assign is_load  = (proc2Dmem_command == BUS_LOAD) && !bad;
  assign is_store = (proc2Dmem_command == BUS_STORE) && !bad;
  // Code 3 behaves exactly like BUS_NONE.
  assign is_idle  = (proc2Dmem_command != BUS_LOAD) && (proc2Dmem_command != BUS_STORE);

  generate
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
      assign match[gi] = sb_valid[gi] && (sb_idx[gi] == idx);
    end
  endgenerate

  // Coalescing guarantees at most one match, so a simple encoder suffices.
  always_comb begin
    hit_slot = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (match[i]) hit_slot = PW'(i);
    end
  end

  assign hit   = |match;
  assign push  = is_store && !hit;
  // A full buffer makes room for a new store by retiring its head in the same cycle.
  assign drain = (is_idle && (count != '0)) || (push && (count == (PW+1)'(SB_DEPTH)));

  always_comb begin
    mem2proc_data = '0;
    if (is_load) mem2proc_data = hit ? sb_data[hit_slot] : mem[idx];
  end

  assign sb_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      sb_valid <= '0;
      mem_err  <= 1'b0;
    end else begin
      mem_err <= bad && !is_idle;
      if (drain) begin
        sb_valid[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      // Ordered after the drain so a full-buffer replace re-validates the slot.
      if (push) begin
        sb_valid[tail] <= 1'b1;
        tail           <= tail + 1'b1;
      end
      if (push && !drain)      count <= count + 1'b1;
      else if (drain && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sb_idx[tail]  <= idx;
      sb_data[tail] <= proc2mem_data;
    end else if (is_store && hit) begin
      sb_data[hit_slot] <= proc2mem_data;
    end
  end

  // Count is cleared asynchronously, so no drain can fire while reset is held.
  always_ff @(posedge clk) begin
    if (drain) mem[sb_idx[head]] <= sb_data[head];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed and random checks of dmem_responder against a queue-based reference model.
module tb_dmem_responder;
  localparam int MEM_WORDS = 1024;
  localparam int SB_DEPTH  = 4;
  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr_s = '0;
  logic [1:0]  cmd_s = '0;
  logic [31:0] data_s = '0;
  logic [31:0] mem2proc_data;
  logic [$clog2(SB_DEPTH):0] sb_count;
  logic        mem_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } ent_t;

  ent_t        sb_q[$];
  logic [31:0] mem_m [MEM_WORDS];
  logic        exp_err = 1'b0;

  dmem_responder #(.MEM_WORDS(MEM_WORDS), .SB_DEPTH(SB_DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .proc2Dmem_addr    (addr_s),
    .proc2Dmem_command (cmd_s),
    .proc2mem_data     (data_s),
    .mem2proc_data     (mem2proc_data),
    .sb_count          (sb_count),
    .mem_err           (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * MEM_WORDS));
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] c, input logic [31:0] a);
    logic [31:0] r;
    int          w;
    r = '0;
    w = int'(a >> 2);
    if (c == C_LOAD && !addr_bad(a)) begin
      r = mem_m[w];
      foreach (sb_q[i]) if (sb_q[i].idx == w) r = sb_q[i].data;
    end
    return r;
  endfunction

  task automatic model_update(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    int w;
    bit found;
    ent_t e;
    w = int'(a >> 2);
    exp_err = (c == C_LOAD || c == C_STORE) && addr_bad(a);
    if (c == C_STORE && !addr_bad(a)) begin
      found = 0;
      foreach (sb_q[i]) if (sb_q[i].idx == w) begin
        sb_q[i].data = d;
        found = 1;
      end
      if (!found) begin
        if (sb_q.size() == SB_DEPTH) begin
          e = sb_q.pop_front();
          mem_m[e.idx] = e.data;
        end
        e.idx = w;
        e.data = d;
        sb_q.push_back(e);
      end
    end else if (c != C_LOAD && c != C_STORE && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      mem_m[e.idx] = e.data;
    end
  endtask

  task automatic do_cycle(input string tag, input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cmd_s = c;
    addr_s = a;
    data_s = d;
    #2;
    check({tag, ":rdata"}, mem2proc_data, model_read(c, a));
    @(posedge clk);
    model_update(c, a, d);
    #1;
    check({tag, ":sb_count"}, 32'(sb_count), 32'(sb_q.size()));
    check({tag, ":mem_err"}, 32'(mem_err), 32'(exp_err));
    $display("txn %s cmd=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h sb_count=%0d mem_err=%0b",
             tag, c, a, d, mem2proc_data, sb_count, mem_err);
  endtask

  task automatic drain_all(input string tag);
    int guard = 0;
    while (sb_q.size() > 0 && guard < 2 * SB_DEPTH) begin
      do_cycle(tag, C_NONE, 32'h0, 32'h0);
      guard++;
    end
  endtask

  initial begin
    logic [1:0]  c;
    logic [31:0] a;
    int          r;

    for (int i = 0; i < MEM_WORDS; i++) mem_m[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset:sb_count", 32'(sb_count), 32'd0);
    check("reset:mem_err", 32'(mem_err), 32'd0);
    check("reset:rdata", mem2proc_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Give the first 64 words known contents.
    for (int i = 0; i < 64; i++) do_cycle("init", C_STORE, 32'(i * 4), 32'h1000_0000 + 32'(i * 3));
    drain_all("init_drain");

    // Store then load next cycle: forwarded, array untouched.
    do_cycle("fwd_st", C_STORE, 32'h10, 32'hAAAA_0001);
    do_cycle("fwd_ld", C_LOAD, 32'h10, 32'h0);
    check("fwd:const_rdata_model", model_read(C_LOAD, 32'h10), 32'hAAAA_0001);
    check("fwd:count_one", 32'(sb_count), 32'd1);
    check("fwd:array4", dut.mem[4], 32'h1000_000C);
    drain_all("fwd_drain");

    // Coalescing to one entry.
    do_cycle("coal_st1", C_STORE, 32'h20, 32'h1);
    do_cycle("coal_st2", C_STORE, 32'h20, 32'h2);
    check("coal:count", 32'(sb_count), 32'd1);
    do_cycle("coal_n1", C_NONE, 32'h0, 32'h0);
    do_cycle("coal_n2", C_NONE, 32'h0, 32'h0);
    do_cycle("coal_ld", C_LOAD, 32'h20, 32'h0);
    check("coal:array8", dut.mem[8], 32'h2);

    // Full buffer: fifth store retires the head.
    for (int i = 0; i < 5; i++) do_cycle("full_st", C_STORE, 32'(i * 4), 32'hB000_0000 + 32'(i));
    check("full:count", 32'(sb_count), 32'd4);
    check("full:array0", dut.mem[0], 32'hB000_0000);
    do_cycle("full_ld", C_LOAD, 32'h0, 32'h0);
    drain_all("full_drain");

    // Bad addresses.
    do_cycle("bad_st_ok", C_STORE, 32'h30, 32'hC0DE_0001);
    do_cycle("bad_ld", C_LOAD, 32'h102, 32'h0);
    do_cycle("bad_st", C_STORE, 32'(4 * MEM_WORDS), 32'hDEAD_BEEF);
    do_cycle("bad_cmd3", 2'd3, 32'h0, 32'h0);
    drain_all("bad_drain");

    // Reset discards buffered stores; array keeps old values.
    do_cycle("rst_st0", C_STORE, 32'h40, 32'hD000_0000);
    do_cycle("rst_st1", C_STORE, 32'h44, 32'hD000_0001);
    do_cycle("rst_st2", C_STORE, 32'h48, 32'hD000_0002);
    do_cycle("rst_bad", C_LOAD, 32'h41, 32'h0);
    @(negedge clk);
    cmd_s = C_NONE;
    rst_n = 1'b0;
    #1;
    check("rst_async:sb_count", 32'(sb_count), 32'd0);
    check("rst_async:mem_err", 32'(mem_err), 32'd0);
    sb_q.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel:sb_count", 32'(sb_count), 32'd0);
    do_cycle("rst_ld0", C_LOAD, 32'h40, 32'h0);
    do_cycle("rst_ld1", C_LOAD, 32'h44, 32'h0);
    do_cycle("rst_ld2", C_LOAD, 32'h48, 32'h0);
    check("rst:array16", dut.mem[16], 32'h1000_0030);

    // Alternating store/load over four addresses: no drain on loads.
    for (int i = 0; i < 8; i++) begin
      a = 32'h80 + 32'((i % 4) * 4);
      do_cycle("alt_st", C_STORE, a, 32'hE000_0000 + 32'(i));
      do_cycle("alt_ld", C_LOAD, a, 32'h0);
    end
    drain_all("alt_drain");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      c = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 15));
      if (r == 0)      a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 1000) * 4);
      else             a = 32'($urandom_range(0, 63) * 4);
      do_cycle("rand", c, a, $urandom);
    end
    drain_all("rand_drain");
    for (int i = 0; i < 64; i++) do_cycle("final_ld", C_LOAD, 32'(i * 4), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words in the data array (power of 2).
REQ-002 SHALL have parameter SB_DEPTH, default 4, number of posted-store buffer entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port proc2Dmem_addr  input  32  byte address from the processor MEM stage.
REQ-006 SHALL have port proc2Dmem_command  input  2  bus command: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; code 3 is treated as BUS_NONE.
REQ-007 SHALL have port proc2mem_data  input  32  store data.
REQ-008 SHALL have port mem2proc_data  output  32  load data, valid in the same cycle as BUS_LOAD.
REQ-009 SHALL have port sb_count  output  log2(SB_DEPTH)+1  occupied store-buffer entries.
REQ-010 SHALL have port mem_err  output  1  registered flag: previous command was misaligned or out of range.

Function
REQ-011 SHALL use a single-port word array: per cycle, either one read (load) or one write (drain); word index = addr[log2(MEM_WORDS)+1:2].
REQ-012 SHALL classify an address as bad if addr[1:0]!=0 or addr>=4*MEM_WORDS; a bad LOAD/STORE SHALL change no buffer or array state, and mem2proc_data SHALL be 0.
REQ-013 SHALL drive mem_err on the edge after each cycle: 1 if that cycle's LOAD/STORE address was bad, else 0.
REQ-014 BUS_LOAD: mem2proc_data SHALL be combinational, the data of the buffer entry matching the word index if one exists, else the array word; zero-cycle latency.
REQ-015 BUS_LOAD SHALL NOT drain the buffer (port busy with read).
REQ-016 BUS_STORE with word index matching a valid entry SHALL overwrite that entry's data in place (coalesce); count unchanged; at most one entry ever matches a given index.
REQ-017 BUS_STORE without a match and count<SB_DEPTH SHALL append at the tail; count+1.
REQ-018 BUS_STORE without a match and count==SB_DEPTH SHALL write the head entry to the array, pop it, and append the new store in the same cycle; count unchanged.
REQ-019 BUS_NONE with count>0 SHALL write the head entry to the array and pop it; count-1.
REQ-020 Buffer SHALL be a FIFO with wrap-around head/tail pointers; drain order equals insertion order of first write to each address.
REQ-021 mem2proc_data SHALL be 0 in any cycle whose command is not BUS_LOAD.
REQ-022 Stores SHALL be visible to a load issued in the cycle after the store (via forwarding), regardless of drain state.
REQ-023 SHALL complete every command in one cycle; no stall or backpressure output exists.

Reset
REQ-024 While rst_n=0: buffer emptied (all entries invalid), head/tail=0, sb_count=0, mem_err=0; pending buffered stores are discarded.
REQ-025 Array contents SHALL NOT be reset; they retain values across reset.
REQ-026 Reset assertion mid-drain SHALL take effect immediately (asynchronous); no partial array write on the asserting edge.

Verification
REQ-027 STORE 0x10<-0xAAAA_0001, next cycle LOAD 0x10 -> mem2proc_data=0xAAAA_0001, sb_count=1, array[4] unchanged.
REQ-028 STORE 0x20<-0x1, STORE 0x20<-0x2, two NONE cycles, LOAD 0x20 -> sb_count 1,1,0,0; load returns 0x2; array[8]=0x2.
REQ-029 SB_DEPTH=4: STOREs to 0x0,0x4,0x8,0xC,0x10 back-to-back -> sb_count 1,2,3,4,4; array[0] written on fifth store; LOAD 0x0 returns first data.
REQ-030 LOAD 0x102 and STORE 4*MEM_WORDS -> mem_err=1 on the following edge for each, mem2proc_data=0, sb_count unchanged.
REQ-031 Three buffered stores then rst_n low for 1 cycle -> sb_count=0, mem_err=0; LOADs of those addresses return pre-store array values.
REQ-032 Alternating LOAD/STORE for 8 cycles with 4 distinct addresses -> no drain on LOAD cycles, all loads return latest stored data.
